// File: rtl/saci_pkg.sv
// Shared SACI link definitions: field widths, derived frame lengths, FSM states.
// Imported by both the SACI master and the saci_slave responder.
package saci_pkg;

  localparam int unsigned CMD_W        = 7;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ACK_TIMEOUT  = 255;

  localparam int unsigned HDR_LEN      = 2 + CMD_W + ADDR_W;
  localparam int unsigned WR_FRAME_LEN = HDR_LEN + DATA_W;
  localparam int unsigned RD_RSP_LEN   = HDR_LEN + DATA_W;

  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_EXEC,
    ST_TX
  } saci_state_e;

endpackage

// File: rtl/saci_shift_reg.sv
// Generic MSB-first shift register with bit counter; clear beats load beats shift.
module saci_shift_reg #(
  parameter int unsigned g_width = 8,
  parameter int unsigned g_cnt_w = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [g_width-1:0] load_data_i,
  input  logic               shift_i,
  input  logic               bit_i,
  output logic [g_width-1:0] data_o,
  output logic [g_cnt_w-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o  <= '0;
      count_o <= '0;
    end else if (clear_i) begin
      data_o  <= '0;
      count_o <= '0;
    end else if (load_i) begin
      data_o  <= load_data_i;
      count_o <= '0;
    end else if (shift_i) begin
      data_o  <= {data_o[g_width-2:0], bit_i};
      count_o <= count_o + g_cnt_w'(1);
    end
  end

endmodule

// File: rtl/saci_slave.sv
// SACI responder: deserialises a frame on cmd_i, runs one req/ack register access,
// then serialises the response frame on rsp_o.
module saci_slave
  import saci_pkg::*;
#(
  parameter int unsigned g_cmd_w       = CMD_W,
  parameter int unsigned g_addr_w      = ADDR_W,
  parameter int unsigned g_data_w      = DATA_W,
  parameter int unsigned g_ack_timeout = ACK_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                sel_n_i,
  input  logic                cmd_i,
  output logic                rsp_o,
  output logic                reg_req_o,
  output logic                reg_wr_o,
  output logic [g_cmd_w-1:0]  reg_cmd_o,
  output logic [g_addr_w-1:0] reg_addr_o,
  output logic [g_data_w-1:0] reg_wdata_o,
  input  logic [g_data_w-1:0] reg_rdata_i,
  input  logic                reg_ack_i,
  output logic                busy_o
);

  localparam int unsigned FLD_W = g_cmd_w + g_addr_w;
  localparam int unsigned RX_W  = g_data_w + FLD_W;
  localparam int unsigned TX_W  = RX_W + 1;
  localparam int unsigned CNT_W = $clog2(TX_W + 1);
  localparam int unsigned TMR_W = $clog2(g_ack_timeout + 1);

  saci_state_e         state_q, state_d;
  logic                rw_q, rw_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                rsp_d, req_d, wr_d;
  logic [g_cmd_w-1:0]  cmd_d;
  logic [g_addr_w-1:0] addr_d;
  logic [g_data_w-1:0] wdata_d;
  logic                rx_clr, rx_shift, tx_clr, tx_load, tx_shift;
  logic [RX_W-1:0]     rx_data;
  logic [CNT_W-1:0]    rx_cnt, rx_last, tx_cnt, tx_last;
  logic [TX_W-1:0]     tx_data, tx_load_data;
  logic [FLD_W-1:0]    fld;
  logic                tx_unused_bits;

  saci_shift_reg #(.g_width(RX_W), .g_cnt_w(CNT_W)) u_rx (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(rx_clr), .load_i(1'b0),
    .load_data_i('0), .shift_i(rx_shift), .bit_i(cmd_i),
    .data_o(rx_data), .count_o(rx_cnt)
  );

  saci_shift_reg #(.g_width(TX_W), .g_cnt_w(CNT_W)) u_tx (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(tx_clr), .load_i(tx_load),
    .load_data_i(tx_load_data), .shift_i(tx_shift), .bit_i(1'b0),
    .data_o(tx_data), .count_o(tx_cnt)
  );

  assign tx_unused_bits = ^tx_data[TX_W-2:0];
  assign busy_o = (state_q != ST_IDLE);

  // rw itself is shifted into rx_data too; a write pushes it out the top, a read leaves it above the fields.
  assign rx_last = (rw_q == RW_WRITE) ? CNT_W'(FLD_W + g_data_w) : CNT_W'(FLD_W);
  assign tx_last = (rw_q == RW_WRITE) ? CNT_W'(FLD_W + 1) : CNT_W'(FLD_W + 1 + g_data_w);
  assign fld     = (rw_q == RW_WRITE) ? rx_data[RX_W-1 -: FLD_W] : rx_data[FLD_W-1:0];
  assign tx_load_data = {rw_q, reg_cmd_o, reg_addr_o,
                         (rw_q == RW_WRITE) ? {g_data_w{1'b0}} : reg_rdata_i};

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    timer_d  = timer_q;
    rsp_d    = 1'b0;
    req_d    = reg_req_o;
    wr_d     = reg_wr_o;
    cmd_d    = reg_cmd_o;
    addr_d   = reg_addr_o;
    wdata_d  = reg_wdata_o;
    rx_clr   = 1'b0;
    rx_shift = 1'b0;
    tx_clr   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sel_n_i && cmd_i) begin
          state_d = ST_RX;
          rx_clr  = 1'b1;
        end
      end
      ST_RX: begin
        rx_shift = 1'b1;
        if (rx_cnt == '0) rw_d = cmd_i;
        else if (rx_cnt == rx_last) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!reg_req_o) begin
          req_d   = 1'b1;
          timer_d = '0;
          wr_d    = rw_q;
          cmd_d   = fld[FLD_W-1 -: g_cmd_w];
          addr_d  = fld[g_addr_w-1:0];
          wdata_d = (rw_q == RW_WRITE) ? rx_data[g_data_w-1:0] : '0;
        end else if (reg_ack_i) begin
          req_d   = 1'b0;
          tx_load = 1'b1;
          rsp_d   = 1'b1;
          state_d = ST_TX;
        end else if (timer_q == TMR_W'(g_ack_timeout - 1)) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_TX: begin
        if (tx_cnt == tx_last) begin
          state_d = ST_IDLE;
        end else begin
          tx_shift = 1'b1;
          rsp_d    = tx_data[TX_W-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && sel_n_i) begin
      state_d  = ST_IDLE;
      rx_clr   = 1'b1;
      tx_clr   = 1'b1;
      rx_shift = 1'b0;
      tx_shift = 1'b0;
      tx_load  = 1'b0;
      req_d    = 1'b0;
      rsp_d    = 1'b0;
      timer_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      timer_q     <= '0;
      rsp_o       <= 1'b0;
      reg_req_o   <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_cmd_o   <= '0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      timer_q     <= timer_d;
      rsp_o       <= rsp_d;
      reg_req_o   <= req_d;
      reg_wr_o    <= wr_d;
      reg_cmd_o   <= cmd_d;
      reg_addr_o  <= addr_d;
      reg_wdata_o <= wdata_d;
    end
  end

endmodule
